// File: rtl/kap_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : kap_ctrl_seq
// Description : Program sequencer for the kap control word stream. Holds a
//               host-loaded program of {rep, kap_word} entries and, on start,
//               replays a window of entries (each repeated rep+1 times) over a
//               valid/ready handshake towards kap_ctrl_dat.
// Revision    : 1.0 - initial release
// ============================================================================
module kap_ctrl_seq #(
   parameter int SELIN_W = 4,
   parameter int BADDR_W = 8,
   parameter int PERIN_W = 6,
   parameter int SLICES  = 4,
   parameter int DEPTH   = 64,
   parameter int AW      = 6,
   parameter int REP_W   = 8
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 cfg_we,
   input  logic [AW-1:0]                                        cfg_addr,
   input  logic [REP_W+SELIN_W+SLICES*(BADDR_W+PERIN_W)-1:0]    cfg_wdat,
   input  logic                                                 start,
   input  logic [AW-1:0]                                        start_addr,
   input  logic [AW:0]                                          start_len,
   input  logic                                                 abort,
   output logic                                                 busy,
   output logic                                                 done,
   output logic                                                 err,
   output logic [SELIN_W+SLICES*(BADDR_W+PERIN_W)-1:0]          t_kap_dat,
   output logic                                                 t_kap_valid,
   input  logic                                                 t_kap_ready
);

   localparam int DAT_W = SELIN_W + SLICES*(BADDR_W+PERIN_W);
   localparam int ENT_W = REP_W + DAT_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [AW-1:0]    c_ADDR_ONE = AW'(1);
   localparam logic [AW:0]      c_CNT_ONE  = (AW+1)'(1);
   localparam logic [REP_W-1:0] c_REP_ONE  = REP_W'(1);

   logic [ENT_W-1:0] r_mem [DEPTH];

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [AW-1:0]    r_addr;       // next entry to read
   logic [AW:0]      r_fcnt;       // entries still to be read
   logic [DAT_W-1:0] r_out_dat;
   logic [REP_W-1:0] r_out_rep;    // repeats left after the current one
   logic             r_out_vld;
   logic [ENT_W-1:0] r_sk;         // prefetched next entry
   logic             r_sk_vld;
   logic             r_err;

   logic [ENT_W-1:0] w_rd_ent;
   logic             w_run;
   logic             w_accept;
   logic             w_hs;
   logic             w_out_free;
   logic             w_rd_en;
   logic             w_last_hs;
   logic             w_busy;
   logic             w_done;

   assign w_rd_ent   = r_mem[r_addr];
   assign w_run      = (r_state == S_FETCH) || (r_state == S_RUN);
   assign w_accept   = (r_state == S_IDLE) && start && !abort;
   assign w_hs       = r_out_vld && t_kap_ready;
   // Output register takes a new entry when empty or its last repeat leaves
   assign w_out_free = !r_out_vld || (w_hs && (r_out_rep == '0));
   // Read only when the result has somewhere to land this edge
   assign w_rd_en    = w_run && !abort && (r_fcnt != '0) && (!r_sk_vld || w_out_free);
   // Final word of the window leaves with nothing buffered or still to read
   assign w_last_hs  = w_hs && (r_out_rep == '0) && !r_sk_vld && (r_fcnt == '0);

   // Program RAM write port; writes only land while idle
   always_ff @(posedge clk) begin
      if (cfg_we && (r_state == S_IDLE)) begin
         r_mem[cfg_addr] <= cfg_wdat;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; abort returns to idle from anywhere and beats start
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!abort && start) begin
               w_state_nxt = (start_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: w_state_nxt = abort ? S_IDLE : S_RUN;
         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_last_hs) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_FETCH, S_RUN: w_busy = 1'b1;
         S_DONE:         w_done = 1'b1;
         default: ;
      endcase
   end

   // Read pointer, output register and one-deep skid for prefetched entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr    <= '0;
         r_fcnt    <= '0;
         r_out_dat <= '0;
         r_out_rep <= '0;
         r_out_vld <= 1'b0;
         r_sk      <= '0;
         r_sk_vld  <= 1'b0;
      end else if (abort) begin
         r_out_vld <= 1'b0;
         r_sk_vld  <= 1'b0;
         r_fcnt    <= '0;
      end else if (w_accept) begin
         r_addr <= start_addr;
         r_fcnt <= start_len;
      end else if (w_run) begin
         if (w_rd_en) begin
            r_addr <= r_addr + c_ADDR_ONE;
            r_fcnt <= r_fcnt - c_CNT_ONE;
         end
         if (w_out_free) begin
            if (r_sk_vld) begin
               r_out_dat <= r_sk[DAT_W-1:0];
               r_out_rep <= r_sk[ENT_W-1:DAT_W];
               r_out_vld <= 1'b1;
            end else if (w_rd_en) begin
               r_out_dat <= w_rd_ent[DAT_W-1:0];
               r_out_rep <= w_rd_ent[ENT_W-1:DAT_W];
               r_out_vld <= 1'b1;
            end else begin
               r_out_vld <= 1'b0;
            end
         end else if (w_hs) begin
            r_out_rep <= r_out_rep - c_REP_ONE;
         end
         if (w_rd_en && (r_sk_vld || !w_out_free)) begin
            r_sk     <= w_rd_ent;
            r_sk_vld <= 1'b1;
         end else if (w_out_free) begin
            r_sk_vld <= 1'b0;
         end
      end
   end

   // Rejected start/config attempt while a run is in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else begin
         r_err <= (start || cfg_we) && (r_state != S_IDLE);
      end
   end

   assign busy        = w_busy;
   assign done        = w_done;
   assign err         = r_err;
   assign t_kap_dat   = r_out_dat;
   assign t_kap_valid = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_kap_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_kap_ctrl_seq
// Description : Self-checking bench for kap_ctrl_seq. Expected words are queued
//               when a run is launched and popped on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kap_ctrl_seq;

   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int REP_W = 8;
   localparam int DAT_W = 60;
   localparam int ENT_W = REP_W + DAT_W;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_we = 1'b0;
   logic [AW-1:0]    cfg_addr = '0;
   logic [ENT_W-1:0] cfg_wdat = '0;
   logic             start = 1'b0;
   logic [AW-1:0]    start_addr = '0;
   logic [AW:0]      start_len = '0;
   logic             abort = 1'b0;
   logic             busy;
   logic             done;
   logic             err;
   logic [DAT_W-1:0] t_kap_dat;
   logic             t_kap_valid;
   logic             t_kap_ready = 1'b1;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int t0     = 0;
   int first_v, done_cyc, done_cnt, err_cnt, vcnt;
   logic             hold_pend = 1'b0;
   logic [DAT_W-1:0] hold_dat;
   logic [DAT_W-1:0] sb[$];

   kap_ctrl_seq dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdat    (cfg_wdat),
      .start       (start),
      .start_addr  (start_addr),
      .start_len   (start_len),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .t_kap_dat   (t_kap_dat),
      .t_kap_valid (t_kap_valid),
      .t_kap_ready (t_kap_ready)
   );

   always #5 clk = ~clk;

   // Cycle counter; cycle k of a run is the interval where cyc == t0 + k
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DAT_W-1:0] mkw(input int k);
      logic [DAT_W-1:0] w;
      w = {28'(k * 3 + 1), 32'(k) * 32'h9E37_79B9};
      return w;
   endfunction

   // Output monitor: scoreboard compare on handshake, stability while stalled
   always @(negedge clk) begin
      logic [63:0] exp;
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err) err_cnt++;
         if (t_kap_valid) begin
            vcnt++;
            if (first_v < 0) first_v = cyc;
            if (hold_pend) chk("hold", 64'(t_kap_dat), 64'(hold_dat));
            if (t_kap_ready) begin
               exp = (sb.size() > 0) ? 64'(sb.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
               chk("word", 64'(t_kap_dat), exp);
               hold_pend = 1'b0;
            end else begin
               hold_pend = 1'b1;
               hold_dat  = t_kap_dat;
            end
         end else begin
            if (hold_pend) chk("valid_dropped", 64'(t_kap_valid), 64'd1);
            hold_pend = 1'b0;
         end
      end
   end

   task automatic wr(input int a, input int rep, input logic [DAT_W-1:0] w);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_wdat = {REP_W'(rep), w};
      @(posedge clk); #1;
      cfg_we   = 1'b0;
   endtask

   task automatic push(input logic [DAT_W-1:0] w, input int n);
      for (int i = 0; i < n; i++) sb.push_back(w);
   endtask

   // Pulse start in cycle 0; returns at the start of cycle 1
   task automatic go(input int a, input int len);
      first_v = -1; done_cyc = -1; done_cnt = 0; err_cnt = 0; vcnt = 0;
      start      = 1'b1;
      start_addr = AW'(a);
      start_len  = (AW+1)'(len);
      t0         = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input bit tog);
      int n;
      n = 0;
      while (done_cnt == 0 && n < maxc) begin
         if (tog) t_kap_ready = ~t_kap_ready;
         @(posedge clk); #1;
         n++;
      end
      t_kap_ready = 1'b1;
      chk("done_seen", 64'(done_cnt), 64'd1);
   endtask

   task automatic prog1();
      wr(0, 0, mkw(1));
      wr(1, 2, mkw(2));
      wr(2, 0, mkw(3));
   endtask

   task automatic push1();
      push(mkw(1), 1);
      push(mkw(2), 3);
      push(mkw(3), 1);
   endtask

   task automatic run1(input string nm);
      push1();
      go(0, 3);
      @(negedge clk);
      chk({nm, "_busy_c1"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      wait_done(50, 1'b0);
      chk({nm, "_first_valid"}, 64'(first_v - t0), 64'd2);
      chk({nm, "_done_cycle"}, 64'(done_cyc - t0), 64'd7);
      chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_err",   64'(err), 64'd0);
      chk("rst_valid", 64'(t_kap_valid), 64'd0);
      chk("rst_dat",   64'(t_kap_dat), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic run at full throughput
      prog1();
      run1("t1");

      // Ready toggling every cycle
      push1();
      go(0, 3);
      wait_done(80, 1'b1);
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);
      chk("t2_valid_cycles_ge", 64'(vcnt >= 5), 64'd1);

      // Address wrap from DEPTH-1 to 0
      wr(63, 1, mkw(63));
      wr(0, 0, mkw(64));
      push(mkw(63), 2);
      push(mkw(64), 1);
      go(63, 2);
      wait_done(50, 1'b0);
      chk("t3_done_cycle", 64'(done_cyc - t0), 64'd5);
      chk("t3_sb_empty", 64'(sb.size()), 64'd0);

      // Zero-length window, then a single entry
      go(0, 0);
      @(negedge clk);
      chk("t4_busy_c1", 64'(busy), 64'd0);
      chk("t4_done_c1", 64'(done), 64'd1);
      repeat (3) begin @(posedge clk); #1; end
      chk("t4_no_valid", 64'(vcnt), 64'd0);
      chk("t4_done_once", 64'(done_cnt), 64'd1);
      wr(5, 0, mkw(5));
      push(mkw(5), 1);
      go(5, 1);
      wait_done(50, 1'b0);
      chk("t4b_first_valid", 64'(first_v - t0), 64'd2);
      chk("t4b_done_cycle", 64'(done_cyc - t0), 64'd3);

      // Rejected config write and start while busy
      prog1();
      push1();
      go(0, 3);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = AW'(2); cfg_wdat = {8'd4, mkw(99)};
      @(posedge clk); #1;
      cfg_we = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(50, 1'b0);
      chk("t5_err_count", 64'(err_cnt), 64'd2);
      chk("t5_done_cycle", 64'(done_cyc - t0), 64'd7);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);

      // Abort right after the second word
      push(mkw(1), 1);
      push(mkw(2), 1);
      go(0, 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("t6_abort_valid", 64'(t_kap_valid), 64'd0);
      chk("t6_abort_busy", 64'(busy), 64'd0);
      repeat (4) begin @(posedge clk); #1; end
      chk("t6_abort_no_done", 64'(done_cnt), 64'd0);
      chk("t6_abort_words", 64'(vcnt), 64'd2);
      chk("t6_abort_sb", 64'(sb.size()), 64'd0);
      run1("t6a_after");

      // Reset in the middle of a run
      push(mkw(1), 1);
      push(mkw(2), 1);
      go(0, 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_valid", 64'(t_kap_valid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_dat", 64'(t_kap_dat), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("t6_rst_no_done", 64'(done_cnt), 64'd0);
      chk("t6_rst_sb", 64'(sb.size()), 64'd0);
      run1("t6r_after");

      // Maximum repeat count
      wr(10, 255, mkw(10));
      push(mkw(10), 256);
      go(10, 1);
      wait_done(400, 1'b0);
      chk("rep_max_done_cycle", 64'(done_cyc - t0), 64'd258);
      chk("rep_max_sb", 64'(sb.size()), 64'd0);

      // Whole program exactly once
      for (int i = 0; i < DEPTH; i++) wr(i, 0, mkw(100 + i));
      for (int i = 0; i < DEPTH; i++) push(mkw(100 + i), 1);
      go(0, DEPTH);
      wait_done(200, 1'b0);
      chk("full_done_cycle", 64'(done_cyc - t0), 64'(DEPTH + 2));
      chk("full_sb", 64'(sb.size()), 64'd0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
